// File: rtl/udp_pkg.sv
// +----------------------------------------------------------------------------+
// | udp_pkg : shared UDP constants, RX FSM state type and keep helper          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package udp_pkg;

   localparam int         UDP_HDR_BYTES = 8;
   localparam logic [7:0] IP_PROTO_UDP  = 8'h11;

   typedef enum logic [1:0] {
      ST_HEADER  = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_PAD     = 2'd2,
      ST_DROP    = 2'd3
   } udp_rx_state_e;

   // Low n byte enables; n >= 8 gives a full beat.
   function automatic logic [7:0] keep_from_count(input logic [15:0] n);
      logic [7:0] k;
      if (n >= 16'd8) k = 8'hFF;
      else            k = 8'((9'd1 << n[2:0]) - 9'd1);
      return k;
   endfunction

endpackage

`default_nettype wire

// File: rtl/udp_csum_acc.sv
// +----------------------------------------------------------------------------+
// | udp_csum_acc : masked 64-bit one's-complement accumulate and 16-bit fold   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module udp_csum_acc (
   input  logic [63:0] data_i,
   input  logic [7:0]  mask_i,
   input  logic        start_i,
   input  logic [31:0] init_i,
   input  logic [31:0] acc_i,
   output logic [31:0] acc_o,
   output logic [15:0] fold_o
);

   logic [31:0] w_sum;
   logic [16:0] w_f1;

   // Words are big-endian: the first byte on the wire is the high byte.
   always_comb begin
      w_sum = start_i ? init_i : acc_i;
      for (int j = 0; j < 4; j++) begin
         w_sum = w_sum + {16'd0,
                          (mask_i[2*j]   ? data_i[16*j +: 8]     : 8'd0),
                          (mask_i[2*j+1] ? data_i[16*j + 8 +: 8] : 8'd0)};
      end
   end

   assign acc_o  = w_sum;
   assign w_f1   = {1'b0, acc_i[15:0]} + {1'b0, acc_i[31:16]};
   assign fold_o = w_f1[15:0] + {15'd0, w_f1[16]};

endmodule

`default_nettype wire

// File: rtl/us_udp_rx_stream.sv
// +----------------------------------------------------------------------------+
// | us_udp_rx_stream : UDP RX - strip header, trim padding, verify checksum    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module us_udp_rx_stream
   import udp_pkg::*;
#(
   parameter string FPGA_TYPE = "usplus"
) (
   input  logic        rx_axis_aclk,
   input  logic        rx_axis_areset,
   input  logic [63:0] ip_rx_axis_tdata,
   input  logic [7:0]  ip_rx_axis_tkeep,
   input  logic        ip_rx_axis_tvalid,
   input  logic        ip_rx_axis_tlast,
   input  logic        ip_rx_axis_tuser,
   output logic [63:0] udp_rx_axis_tdata,
   output logic [7:0]  udp_rx_axis_tkeep,
   output logic        udp_rx_axis_tvalid,
   output logic        udp_rx_axis_tlast,
   output logic        udp_rx_axis_tuser,
   input  logic [31:0] recv_src_ip_addr,
   input  logic [31:0] recv_dst_ip_addr
);

   if (FPGA_TYPE == "7series") begin : g_fam_7series
   end else begin : g_fam_ultrascale
   end

   udp_rx_state_e state_q, state_d;
   logic [15:0]   rem_q, rem_d;
   logic          err_q, err_d;
   logic          cen_q, cen_d;

   logic          s1_valid_q, s1_last_q, s1_err_q, s1_cen_q;
   logic [63:0]   s1_data_q;
   logic [7:0]    s1_keep_q;
   logic [31:0]   acc_q;

   logic [63:0]   out_data_q;
   logic [7:0]    out_keep_q;
   logic          out_valid_q, out_last_q, out_user_q;

   logic [15:0]   w_len, w_csum, w_fold;
   logic [31:0]   w_pseudo, w_acc_sum;
   logic [3:0]    w_in_cnt;
   logic          w_fwd, w_out_last, w_trunc, w_acc_en, w_acc_start, w_reach;
   logic [7:0]    w_out_keep, w_acc_mask;

   assign w_len  = {ip_rx_axis_tdata[39:32], ip_rx_axis_tdata[47:40]};
   assign w_csum = {ip_rx_axis_tdata[55:48], ip_rx_axis_tdata[63:56]};
   assign w_pseudo = {16'd0, recv_src_ip_addr[31:16]} + {16'd0, recv_src_ip_addr[15:0]}
                   + {16'd0, recv_dst_ip_addr[31:16]} + {16'd0, recv_dst_ip_addr[15:0]}
                   + {24'd0, IP_PROTO_UDP} + {16'd0, w_len};

   always_comb begin
      w_in_cnt = 4'd0;
      for (int i = 0; i < 8; i++) w_in_cnt = w_in_cnt + {3'd0, ip_rx_axis_tkeep[i]};
   end

   assign w_reach = (rem_q <= {12'd0, w_in_cnt});

   udp_csum_acc u_csum (
      .data_i  (ip_rx_axis_tdata),
      .mask_i  (w_acc_mask),
      .start_i (w_acc_start),
      .init_i  (w_pseudo),
      .acc_i   (acc_q),
      .acc_o   (w_acc_sum),
      .fold_o  (w_fold)
   );

   always_ff @(posedge rx_axis_aclk or posedge rx_axis_areset) begin
      if (rx_axis_areset) state_q <= ST_HEADER;
      else                state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (ip_rx_axis_tvalid) begin
         unique case (state_q)
            ST_HEADER:  if (!ip_rx_axis_tlast)
                           state_d = (w_len <= 16'(UDP_HDR_BYTES)) ? ST_DROP : ST_PAYLOAD;
            ST_PAYLOAD: if (ip_rx_axis_tlast) state_d = ST_HEADER;
                        else if (w_reach)     state_d = ST_PAD;
            default:    if (ip_rx_axis_tlast) state_d = ST_HEADER;
         endcase
      end
   end

   always_comb begin
      w_fwd       = 1'b0;
      w_out_keep  = ip_rx_axis_tkeep;
      w_out_last  = 1'b0;
      w_trunc     = 1'b0;
      w_acc_en    = 1'b0;
      w_acc_start = 1'b0;
      w_acc_mask  = 8'hFF;
      rem_d       = rem_q;
      err_d       = err_q;
      cen_d       = cen_q;
      if (ip_rx_axis_tvalid) begin
         unique case (state_q)
            ST_HEADER: if (!ip_rx_axis_tlast) begin
               w_acc_en    = 1'b1;
               w_acc_start = 1'b1;
               rem_d       = w_len - 16'(UDP_HDR_BYTES);
               err_d       = ip_rx_axis_tuser;
               cen_d       = (w_csum != 16'd0);
            end
            ST_PAYLOAD: begin
               w_fwd    = 1'b1;
               w_acc_en = 1'b1;
               err_d    = err_q | ip_rx_axis_tuser;
               if (w_reach) begin
                  w_out_keep = keep_from_count(rem_q);
                  w_acc_mask = w_out_keep;
                  w_out_last = 1'b1;
               end else begin
                  w_acc_mask = ip_rx_axis_tkeep;
                  rem_d      = rem_q - {12'd0, w_in_cnt};
                  w_out_last = ip_rx_axis_tlast;
                  w_trunc    = ip_rx_axis_tlast;
               end
            end
            default: ;
         endcase
      end
   end

   // Stage 1: beat, per-packet flags and running checksum.
   always_ff @(posedge rx_axis_aclk or posedge rx_axis_areset) begin
      if (rx_axis_areset) begin
         rem_q      <= 16'd0;
         err_q      <= 1'b0;
         cen_q      <= 1'b0;
         acc_q      <= 32'd0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= 64'd0;
         s1_keep_q  <= 8'd0;
         s1_last_q  <= 1'b0;
         s1_err_q   <= 1'b0;
         s1_cen_q   <= 1'b0;
      end else begin
         rem_q      <= rem_d;
         err_q      <= err_d;
         cen_q      <= cen_d;
         s1_valid_q <= w_fwd;
         if (w_acc_en) acc_q <= w_acc_sum;
         if (w_fwd) begin
            s1_data_q <= ip_rx_axis_tdata;
            s1_keep_q <= w_out_keep;
            s1_last_q <= w_out_last;
            s1_err_q  <= err_d | w_trunc;
            s1_cen_q  <= cen_q;
         end
      end
   end

   // Stage 2: fold the accumulated sum and drive the output stream.
   always_ff @(posedge rx_axis_aclk or posedge rx_axis_areset) begin
      if (rx_axis_areset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= 64'd0;
         out_keep_q  <= 8'd0;
         out_last_q  <= 1'b0;
         out_user_q  <= 1'b0;
      end else begin
         out_valid_q <= s1_valid_q;
         out_data_q  <= s1_data_q;
         out_keep_q  <= s1_keep_q;
         out_last_q  <= s1_valid_q & s1_last_q;
         out_user_q  <= s1_valid_q & s1_last_q &
                        (s1_err_q | (s1_cen_q & (w_fold != 16'hFFFF)));
      end
   end

   assign udp_rx_axis_tdata  = out_data_q;
   assign udp_rx_axis_tkeep  = out_keep_q;
   assign udp_rx_axis_tvalid = out_valid_q;
   assign udp_rx_axis_tlast  = out_last_q;
   assign udp_rx_axis_tuser  = out_user_q;

endmodule

`default_nettype wire

// File: tb/tb_us_udp_rx_stream.sv
// +----------------------------------------------------------------------------+
// | tb_us_udp_rx_stream : directed self-checking bench for us_udp_rx_stream    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_us_udp_rx_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] in_data = '0;
   logic [7:0]  in_keep = '0;
   logic        in_valid = 1'b0, in_last = 1'b0, in_user = 1'b0;
   logic [31:0] src_ip = '0, dst_ip = '0;
   logic [63:0] out_data;
   logic [7:0]  out_keep;
   logic        out_valid, out_last, out_user;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
   } beat_t;

   beat_t got_q[$];
   beat_t exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   always #5 clk = ~clk;

   us_udp_rx_stream #(.FPGA_TYPE("usplus")) dut (
      .rx_axis_aclk       (clk),
      .rx_axis_areset     (rst),
      .ip_rx_axis_tdata   (in_data),
      .ip_rx_axis_tkeep   (in_keep),
      .ip_rx_axis_tvalid  (in_valid),
      .ip_rx_axis_tlast   (in_last),
      .ip_rx_axis_tuser   (in_user),
      .udp_rx_axis_tdata  (out_data),
      .udp_rx_axis_tkeep  (out_keep),
      .udp_rx_axis_tvalid (out_valid),
      .udp_rx_axis_tlast  (out_last),
      .udp_rx_axis_tuser  (out_user),
      .recv_src_ip_addr   (src_ip),
      .recv_dst_ip_addr   (dst_ip)
   );

   always @(negedge clk)
      if (!rst && out_valid) got_q.push_back({out_data, out_keep, out_last, out_user});

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
      @(posedge clk); #1;
      in_data = d; in_keep = k; in_valid = 1'b1; in_last = l; in_user = u;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_valid = 1'b0; in_last = 1'b0; in_user = 1'b0;
      end
   endtask

   function automatic logic [63:0] pat(input int k);
      return 64'h0101_0101_0101_0101 * 64'(k);
   endfunction

   function automatic logic [63:0] hdr(input logic [15:0] sp, dp, len, cs);
      return {cs[7:0], cs[15:8], len[7:0], len[15:8], dp[7:0], dp[15:8], sp[7:0], sp[15:8]};
   endfunction

   // Reference checksum over payload bytes produced by pat(): byte b holds b/8+1.
   function automatic logic [15:0] ref_csum(input logic [31:0] sip, dip,
                                            input logic [15:0] sp, dp, len);
      logic [31:0] s;
      logic [7:0]  hi, lo;
      logic [15:0] c;
      int          p;
      p = int'(len) - 8;
      s = 32'(sip[31:16]) + 32'(sip[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0])
        + 32'h11 + 32'(len) + 32'(sp) + 32'(dp) + 32'(len);
      for (int b = 0; b < p; b += 2) begin
         hi = 8'(b / 8 + 1);
         lo = (b + 1 < p) ? 8'((b + 1) / 8 + 1) : 8'd0;
         s  = s + {16'd0, hi, lo};
      end
      s = 32'(s[15:0]) + 32'(s[31:16]);
      s = 32'(s[15:0]) + 32'(s[31:16]);
      c = ~s[15:0];
      if (c == 16'd0) c = 16'hFFFF;
      return c;
   endfunction

   task automatic send_pkt(input logic [63:0] h, input int n_pay, input logic [7:0] last_keep,
                           input int err_at, input bit gaps);
      drive(h, 8'hFF, n_pay == 0, err_at == 0);
      for (int k = 1; k <= n_pay; k++) begin
         if (gaps && (k % 3 == 0)) idle(1);
         drive(pat(k), (k == n_pay) ? last_keep : 8'hFF, k == n_pay, k == err_at);
      end
   endtask

   task automatic expect_pkt(input int n, input logic [7:0] last_keep, input logic user);
      for (int k = 1; k <= n; k++)
         exp_q.push_back({pat(k), (k == n) ? last_keep : 8'hFF, k == n, (k == n) & user});
   endtask

   task automatic compare(input string name);
      int n;
      idle(6);
      check_val({name, ".count"}, 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check_val($sformatf("%s.b%0d.data", name, i), got_q[i].data, exp_q[i].data);
         check_val($sformatf("%s.b%0d.keep", name, i), 64'(got_q[i].keep), 64'(exp_q[i].keep));
         check_val($sformatf("%s.b%0d.last", name, i), 64'(got_q[i].last), 64'(exp_q[i].last));
         check_val($sformatf("%s.b%0d.user", name, i), 64'(got_q[i].user), 64'(exp_q[i].user));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [15:0] cs;
      bit          seen;

      repeat (3) @(posedge clk);
      #1;
      check_val("rst.tvalid", 64'(out_valid), 64'd0);
      check_val("rst.tdata",  out_data,       64'd0);
      check_val("rst.tkeep",  64'(out_keep),  64'd0);
      check_val("rst.tlast",  64'(out_last),  64'd0);
      check_val("rst.tuser",  64'(out_user),  64'd0);
      @(posedge clk); #1 rst = 1'b0;

      send_pkt(hdr(16'h8080, 16'h8081, 16'h0058, 16'h0000), 16, 8'hFF, -1, 1'b0);
      expect_pkt(10, 8'hFF, 1'b0);
      compare("pad_trim");

      send_pkt(hdr(16'h1000, 16'h2000, 16'h00A8, 16'h0000), 20, 8'hFF, -1, 1'b1);
      expect_pkt(20, 8'hFF, 1'b0);
      compare("gaps20");

      send_pkt(hdr(16'h1000, 16'h2000, 16'h0013, 16'h0000), 2, 8'hFF, -1, 1'b0);
      expect_pkt(2, 8'h07, 1'b0);
      compare("p11");

      src_ip = 32'hC0A8_010A;
      dst_ip = 32'hC0A8_010B;
      cs = ref_csum(src_ip, dst_ip, 16'h1234, 16'h5678, 16'h0015);
      send_pkt(hdr(16'h1234, 16'h5678, 16'h0015, cs), 3, 8'hFF, -1, 1'b0);
      expect_pkt(2, 8'h1F, 1'b0);
      compare("csum_ok");

      send_pkt(hdr(16'h1234, 16'h5678, 16'h0015, cs ^ 16'h0100), 3, 8'hFF, -1, 1'b0);
      expect_pkt(2, 8'h1F, 1'b1);
      compare("csum_bad");

      send_pkt(hdr(16'h1000, 16'h2000, 16'h0058, 16'h0000), 5, 8'hFF, -1, 1'b0);
      send_pkt(hdr(16'h1000, 16'h2000, 16'h0018, 16'h0000), 2, 8'hFF, -1, 1'b0);
      expect_pkt(5, 8'hFF, 1'b1);
      expect_pkt(2, 8'hFF, 1'b0);
      compare("trunc_b2b");

      send_pkt(hdr(16'h1000, 16'h2000, 16'h0058, 16'h0000), 3, 8'h0F, -1, 1'b0);
      expect_pkt(3, 8'h0F, 1'b1);
      compare("trunc_partial");

      send_pkt(hdr(16'h1000, 16'h2000, 16'h0004, 16'h0000), 3, 8'hFF, -1, 1'b0);
      send_pkt(hdr(16'h1000, 16'h2000, 16'h0008, 16'h0000), 2, 8'hFF, -1, 1'b0);
      send_pkt(hdr(16'h1000, 16'h2000, 16'h0010, 16'h0000), 0, 8'hFF, -1, 1'b0);
      send_pkt(hdr(16'h1000, 16'h2000, 16'h0010, 16'h0000), 1, 8'hFF, -1, 1'b0);
      expect_pkt(1, 8'hFF, 1'b0);
      compare("drops");

      send_pkt(hdr(16'h1000, 16'h2000, 16'h0028, 16'h0000), 4, 8'hFF, 2, 1'b0);
      expect_pkt(4, 8'hFF, 1'b1);
      compare("in_err");

      drive(hdr(16'h1000, 16'h2000, 16'h0058, 16'h0000), 8'hFF, 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) drive(pat(k), 8'hFF, 1'b0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check_val("mid.valid_before_rst", 64'(seen), 64'd1);
      rst = 1'b1;
      #1;
      check_val("mid.tvalid", 64'(out_valid), 64'd0);
      check_val("mid.tdata",  out_data,       64'd0);
      check_val("mid.tlast",  64'(out_last),  64'd0);
      idle(2);
      rst = 1'b0;
      got_q.delete();
      exp_q.delete();
      send_pkt(hdr(16'h1000, 16'h2000, 16'h0018, 16'h0000), 2, 8'hFF, -1, 1'b0);
      expect_pkt(2, 8'hFF, 1'b0);
      compare("after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
